alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Sequential command front-end for the 4-bit combinational ALU. It accepts operation commands over a valid/ready handshake, drives registered operands and select into the ALU, and captures the 5-bit ALU result. It returns each result over a second valid/ready handshake and keeps a running accumulator, so operations can be chained.

## Interface
- Parameters: none; widths are fixed at 4-bit operands, 3-bit select and 5-bit result.
- Op encoding on `cmd_op` and `alu_sel`:
  - 000 copy
  - 001 add
  - 010 sub
  - 011 div
  - 100 mod
  - 101 shift left
  - 110 shift right
  - 111 compare (in1>in2)
- One clock; reset is asynchronous and active-high.

Ports:
- `clk` in 1: sole clock, all state on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_op` in 3: ALU operation.
- `cmd_opa` in 4: operand A.
- `cmd_opb` in 4: operand B.
- `cmd_use_acc` in 1: 1 = use `acc[3:0]` as operand A instead of `cmd_opa`.
- `alu_in1` out 4: registered operand to the ALU.
- `alu_in2` out 4: registered operand to the ALU.
- `alu_sel` out 3: registered select to the ALU.
- `alu_out` in 5: ALU result, combinational from `alu_in1`/`alu_in2`/`alu_sel`.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_data` out 5: captured result.
- `rsp_err` out 1: error flag for this result.
- `acc` out 5: accumulator, equal to the last successful result.
- `ops_done` out 8: count of completed responses; wraps 255 -> 0.

## Operation
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - `cmd_ready`=1; this is decoded from state, so it also reads 1 while `rst` is held.
  - On `cmd_valid` the command is accepted at that edge:
    - `alu_in1` <= (`cmd_use_acc` ? `acc[3:0]` : `cmd_opa`)
    - `alu_in2` <= `cmd_opb`
    - `alu_sel` <= `cmd_op`
    - Next state DRIVE.
- DRIVE:
  - `cmd_ready`=0.
  - The ALU inputs have been stable for one full cycle.
  - At the edge: `rsp_data` <= `alu_out`, `acc` <= `alu_out`, `rsp_err` <= 0; next state RESP.
- RESP:
  - `rsp_valid`=1, `cmd_ready`=0.
  - `rsp_data` and `rsp_err` are held stable until `rsp_ready`.
  - On `rsp_valid` && `rsp_ready`: `ops_done` increments by 1 (wraps) and next state is IDLE.
- `alu_in1`, `alu_in2` and `alu_sel` hold their last values outside command acceptance; they are never changed mid-operation.
- Width rule: `cmd_use_acc` truncates `acc` to its low 4 bits; bit 4 is discarded with no flag.
- A `cmd_valid` asserted outside IDLE is ignored and not queued; the source must hold it until `cmd_ready`.
- Reset, including mid-operation, applies immediately:
  - State -> IDLE.
  - `alu_in1`, `alu_in2`, `alu_sel`, `rsp_data`, `acc` -> 0.
  - `rsp_err` -> 0, `ops_done` -> 0, `rsp_valid` -> 0.
  - Any in-flight command is dropped and produces no response.

## Timing
- Command accepted at edge E0 -> `rsp_valid` high after edge E1; accept-to-response latency is 2 cycles.
- With `rsp_ready` tied high, RESP lasts 1 cycle, giving a maximum throughput of 1 command per 3 cycles.
- `rsp_valid` is a registered state decode and has no combinational path from `rsp_ready`.
- `cmd_ready` depends on state only and has no combinational path from `cmd_valid`.
- Reset values of all outputs:
  - `cmd_ready`=1, `rsp_valid`=0, `rsp_err`=0.
  - `rsp_data`, `acc`, `alu_in1`, `alu_in2`, `alu_sel`, `ops_done` = 0.

## Configuration
- Macro: `ALU_SEQ_DIVZERO_CHK_EN`.
- Defined:
  - In DRIVE, if `alu_sel` is div (011) or mod (100) and `alu_in2`==0, then `rsp_data` <= 5'h1F and `rsp_err` <= 1.
  - `acc` is left unchanged in that case.
  - Otherwise behaviour is as in Operation.
- Undefined:
  - No check is made; `alu_out` is captured as-is in all cases.
  - `rsp_err` is constant 0.

## Test plan
All scenarios use the 4-bit combinational ALU as the downstream model.
- Add: reset, then op=001, opa=7, opb=9, `rsp_ready`=1 -> `rsp_valid` 2 cycles after accept, `rsp_data`=16, `acc`=16, `ops_done`=1.
- Chained: copy opa=5, then sub with `use_acc`=1, opb=3, then shl with `use_acc`=1 -> `rsp_data` 5, 2, 4; `acc`=4; `ops_done`=3.
- Backpressure: `rsp_ready`=0 for 5 cycles after a cmp with opa=9, opb=2 -> `rsp_valid` and `rsp_data`=1 stay stable and `cmd_ready`=0 throughout. Raise `rsp_ready` -> back to IDLE in 1 cycle.
- Div by zero: op=011, opa=6, opb=0.
  - With the macro: `rsp_data`=31, `rsp_err`=1, `acc` unchanged.
  - Without the macro: `rsp_err`=0 and `rsp_data` equals the ALU model output.
- Reset mid-op: assert `rst` during DRIVE -> all outputs go to their reset values asynchronously, no response is produced, `ops_done`=0, `cmd_ready`=1 after release.
- Counter wrap: 256 back-to-back commands -> `ops_done` returns to 0.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and response signals of the ALU command sequencer.
// Latency: none, wiring only.
// Backpressure: carries cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes.
interface alu_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_opa;
    logic [3:0] cmd_opb;
    logic       cmd_use_acc;
    logic [3:0] alu_in1;
    logic [3:0] alu_in2;
    logic [2:0] alu_sel;
    logic [4:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [4:0] rsp_data;
    logic       rsp_err;
    logic [4:0] acc;
    logic [7:0] ops_done;

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_opa, cmd_opb, cmd_use_acc, alu_out, rsp_ready,
        output cmd_ready, alu_in1, alu_in2, alu_sel, rsp_valid, rsp_data, rsp_err, acc, ops_done
    );

    // Command source / response sink / ALU side.
    modport master (
        output cmd_valid, cmd_op, cmd_opa, cmd_opb, cmd_use_acc, alu_out, rsp_ready,
        input  cmd_ready, alu_in1, alu_in2, alu_sel, rsp_valid, rsp_data, rsp_err, acc, ops_done
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Sequential command front-end for a 4-bit combinational ALU with running accumulator.
// Latency: command accepted at edge E0, response valid after edge E1 (2 cycles).
// Backpressure: one command in flight; RESP holds until rsp_ready, cmd_ready low meanwhile.
// Optional feature: define ALU_SEQ_DIVZERO_CHK_EN to flag div/mod by zero (rsp_data=1F, rsp_err=1).
module alu_cmd_sequencer (
    input  logic                 clk,
    input  logic                 rst,
    alu_cmd_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       accept;
    logic       capture;
    logic       complete;
    logic       div_zero;

    logic [3:0] in1_q;
    logic [3:0] in2_q;
    logic [2:0] sel_q;
    logic [4:0] data_q;
    logic       err_q;
    logic [4:0] acc_q;
    logic [7:0] ops_q;

`ifdef ALU_SEQ_DIVZERO_CHK_EN
    // Division and modulo by zero are trapped instead of passing the ALU's result through.
    assign div_zero = ((sel_q == 3'b011) || (sel_q == 3'b100)) && (in2_q == 4'd0);
`else
    // No trap: the ALU result is always captured as-is and rsp_err stays 0.
    assign div_zero = 1'b0;
`endif

    // State register; reset drops any in-flight command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        capture  = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept  = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ALU operands are loaded only on acceptance so they stay stable through DRIVE and RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in1_q <= 4'd0;
            in2_q <= 4'd0;
            sel_q <= 3'd0;
        end else if (accept) begin
            // Accumulator bit 4 is silently dropped when chaining.
            in1_q <= bus.cmd_use_acc ? acc_q[3:0] : bus.cmd_opa;
            in2_q <= bus.cmd_opb;
            sel_q <= bus.cmd_op;
        end
    end

    // Capture the ALU result after its inputs have been stable for a full cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= 5'd0;
            err_q  <= 1'b0;
            acc_q  <= 5'd0;
        end else if (capture) begin
            if (div_zero) begin
                data_q <= 5'h1F;
                err_q  <= 1'b1;
            end else begin
                data_q <= bus.alu_out;
                err_q  <= 1'b0;
                acc_q  <= bus.alu_out;
            end
        end
    end

    // Completed-response counter, wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_q <= 8'd0;
        end else if (complete) begin
            ops_q <= ops_q + 8'd1;
        end
    end

    // Handshake outputs are pure state decodes: no path from cmd_valid or rsp_ready.
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.alu_in1   = in1_q;
    assign bus.alu_in2   = in2_q;
    assign bus.alu_sel   = sel_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;
    assign bus.acc       = acc_q;
    assign bus.ops_done  = ops_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural 4-bit ALU on the alu_* lines.
// Stimulus and sampling happen on the falling clock edge.
// Expected results are queued when a command is driven and popped when the response appears.
module tb_alu_cmd_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    typedef struct {
        logic [3:0] in1;
        logic [3:0] in2;
        logic [2:0] sel;
        logic [4:0] data;
        logic       err;
        logic [4:0] acc;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] model_acc;
    logic [7:0] model_ops;

    alu_cmd_sequencer_if bus ();

    alu_cmd_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference 4-bit ALU; division/modulo by zero yield 0.
    function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        case (s)
            3'b000:  return {1'b0, a};
            3'b001:  return {1'b0, a} + {1'b0, b};
            3'b010:  return {1'b0, a} - {1'b0, b};
            3'b011:  return (b == 4'd0) ? 5'd0 : {1'b0, a / b};
            3'b100:  return (b == 4'd0) ? 5'd0 : {1'b0, a % b};
            3'b101:  return {a, 1'b0};
            3'b110:  return {2'b00, a[3:1]};
            default: return (a > b) ? 5'd1 : 5'd0;
        endcase
    endfunction

    assign bus.alu_out = alu_model(bus.alu_in1, bus.alu_in2, bus.alu_sel);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one command starting at a falling edge, hold the response for 'hold' cycles, then accept it.
    task automatic do_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic ua, input int hold);
        exp_t e;
        exp_t got;
        int   n;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 10) begin
            errors++;
            $display("FAIL cmd_ready_timeout got %b want 1", bus.cmd_ready);
        end
        e.in1  = ua ? model_acc[3:0] : a;
        e.in2  = b;
        e.sel  = op;
        e.data = alu_model(e.in1, b, op);
        e.err  = 1'b0;
        e.acc  = e.data;
`ifdef ALU_SEQ_DIVZERO_CHK_EN
        if ((op == 3'b011 || op == 3'b100) && b == 4'd0) begin
            e.data = 5'h1F;
            e.err  = 1'b1;
            e.acc  = model_acc;
        end
`endif
        model_acc = e.acc;
        sb.push_back(e);

        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_opa     = a;
        bus.cmd_opb     = b;
        bus.cmd_use_acc = ua;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_opa   = ~a;
        // One cycle after accept: DRIVE
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL drive_cmd_ready got %b want 0", bus.cmd_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL drive_rsp_valid got %b want 0", bus.rsp_valid); end
        checks++; if (bus.alu_in1 !== e.in1) begin errors++; $display("FAIL alu_in1 got %0d want %0d", bus.alu_in1, e.in1); end
        checks++; if (bus.alu_in2 !== e.in2) begin errors++; $display("FAIL alu_in2 got %0d want %0d", bus.alu_in2, e.in2); end
        checks++; if (bus.alu_sel !== e.sel) begin errors++; $display("FAIL alu_sel got %0d want %0d", bus.alu_sel, e.sel); end
        @(negedge clk);
        // Two cycles after accept: RESP
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_latency got %b want 1", bus.rsp_valid); end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got 0 want 1 entries");
        end else begin
            got = sb.pop_front();
            if (bus.rsp_data !== got.data || bus.rsp_err !== got.err || bus.acc !== got.acc) begin
                errors++;
                $display("FAIL rsp_result got data %0d err %b acc %0d want data %0d err %b acc %0d",
                         bus.rsp_data, bus.rsp_err, bus.acc, got.data, got.err, got.acc);
            end
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== got.data || bus.cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL backpressure_hold got valid %b data %0d rdy %b want 1 %0d 0",
                             bus.rsp_valid, bus.rsp_data, bus.cmd_ready, got.data);
                end
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        model_ops = model_ops + 8'd1;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_rsp_valid got %b want 0", bus.rsp_valid); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_cmd_ready got %b want 1", bus.cmd_ready); end
        checks++; if (bus.ops_done !== model_ops) begin errors++; $display("FAIL ops_done got %0d want %0d", bus.ops_done, model_ops); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", bus.rsp_err); end
        checks++; if (bus.rsp_data !== 5'd0) begin errors++; $display("FAIL reset_rsp_data got %0d want 0", bus.rsp_data); end
        checks++; if (bus.acc !== 5'd0) begin errors++; $display("FAIL reset_acc got %0d want 0", bus.acc); end
        checks++; if (bus.alu_in1 !== 4'd0 || bus.alu_in2 !== 4'd0 || bus.alu_sel !== 3'd0) begin
            errors++; $display("FAIL reset_alu_regs got %0d %0d %0d want 0 0 0", bus.alu_in1, bus.alu_in2, bus.alu_sel); end
        checks++; if (bus.ops_done !== 8'd0) begin errors++; $display("FAIL reset_ops_done got %0d want 0", bus.ops_done); end
        rst = 1'b0;
        model_acc = 5'd0;
        model_ops = 8'd0;
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_cmd_ready got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_add();
        do_op(3'b001, 4'd7, 4'd9, 1'b0, 0);
        checks++; if (bus.acc !== 5'd16) begin errors++; $display("FAIL add_acc got %0d want 16", bus.acc); end
    endtask

    task automatic test_chained();
        do_op(3'b000, 4'd5, 4'd0, 1'b0, 0);
        do_op(3'b010, 4'd15, 4'd3, 1'b1, 0);
        do_op(3'b101, 4'd15, 4'd1, 1'b1, 0);
        checks++; if (bus.acc !== 5'd4) begin errors++; $display("FAIL chain_acc got %0d want 4", bus.acc); end
        // Acc bit 4 is dropped: 7+9=16 chained into copy yields 0.
        do_op(3'b001, 4'd7, 4'd9, 1'b0, 0);
        do_op(3'b000, 4'd3, 4'd0, 1'b1, 0);
        checks++; if (bus.acc !== 5'd0) begin errors++; $display("FAIL truncate_acc got %0d want 0", bus.acc); end
    endtask

    task automatic test_backpressure();
        do_op(3'b111, 4'd9, 4'd2, 1'b0, 5);
        do_op(3'b110, 4'd13, 4'd0, 1'b0, 2);
    endtask

    task automatic test_div_zero();
        do_op(3'b000, 4'd6, 4'd0, 1'b0, 0);
        do_op(3'b011, 4'd6, 4'd0, 1'b0, 0);
        do_op(3'b100, 4'd7, 4'd0, 1'b0, 1);
        do_op(3'b100, 4'd7, 4'd3, 1'b0, 0);
        do_op(3'b011, 4'd14, 4'd4, 1'b0, 0);
    endtask

    task automatic test_reset_mid_op();
        do_op(3'b000, 4'd10, 4'd0, 1'b0, 0);
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = 3'b001;
        bus.cmd_opa     = 4'd1;
        bus.cmd_opb     = 4'd1;
        bus.cmd_use_acc = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin
            errors++; $display("FAIL midrst_handshake got rdy %b vld %b err %b want 1 0 0", bus.cmd_ready, bus.rsp_valid, bus.rsp_err); end
        checks++; if (bus.acc !== 5'd0 || bus.rsp_data !== 5'd0) begin
            errors++; $display("FAIL midrst_data got acc %0d data %0d want 0 0", bus.acc, bus.rsp_data); end
        checks++; if (bus.alu_in1 !== 4'd0 || bus.alu_in2 !== 4'd0 || bus.alu_sel !== 3'd0) begin
            errors++; $display("FAIL midrst_alu_regs got %0d %0d %0d want 0 0 0", bus.alu_in1, bus.alu_in2, bus.alu_sel); end
        checks++; if (bus.ops_done !== 8'd0) begin errors++; $display("FAIL midrst_ops_done got %0d want 0", bus.ops_done); end
        @(negedge clk);
        rst = 1'b0;
        model_acc = 5'd0;
        model_ops = 8'd0;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
                errors++; $display("FAIL midrst_no_rsp got vld %b rdy %b want 0 1", bus.rsp_valid, bus.cmd_ready);
            end
        end
        do_op(3'b001, 4'd2, 4'd3, 1'b1, 0);
    endtask

    task automatic test_counter_wrap();
        for (int i = 0; i < 256; i++) begin
            do_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 0);
        end
        // ops_done was 1 before the loop, so 256 more lands back on 1; one reset makes it 0 and 256 wraps to 0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_acc = 5'd0;
        model_ops = 8'd0;
        for (int i = 0; i < 256; i++) begin
            do_op(3'b001, 4'(i), 4'(i >> 4), 1'b0, 0);
        end
        checks++; if (bus.ops_done !== 8'd0) begin errors++; $display("FAIL wrap_ops_done got %0d want 0", bus.ops_done); end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        model_acc       = 5'd0;
        model_ops       = 8'd0;
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 3'd0;
        bus.cmd_opa     = 4'd0;
        bus.cmd_opb     = 4'd0;
        bus.cmd_use_acc = 1'b0;
        bus.rsp_ready   = 1'b0;
        test_reset();
        test_add();
        test_chained();
        test_backpressure();
        test_div_zero();
        test_reset_mid_op();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
